// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer.
// Holds the 2-bit state encoding (so a bench can monitor state by name)
// and the packed bundle of fetch control strobes.
package fetch_ctrl_pkg;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  typedef enum logic [1:0] {
    S_BOOT  = BOOT,
    S_FETCH = FETCH,
    S_HOLD  = HOLD,
    S_DRAIN = DRAIN
  } state_t;

  // Fetch control strobes, one bit per top-level control output.
  typedef struct packed {
    logic imem_req;
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic hold_capture;
    logic ifid_sel_hold;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clr (sync clear, wins over en), en (count enable),
//        count (current value; holds at all-ones instead of wrapping).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC / IF-ID enables, instruction-memory request and
// hold-buffer select for a variable-latency instruction memory.
// Ports: clk, rst (sync, active-high); ImemReady, DecodeStall, Redirect in;
//        ImemReq, PCWriteEnable, IFIDWriteEnable, IFIDFlush, HoldCapture,
//        IFIDSelHold out (combinational from state and inputs);
//        StallCycles out (registered, saturating).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ImemReady,
  input  logic             DecodeStall,
  input  logic             Redirect,
  output logic             ImemReq,
  output logic             PCWriteEnable,
  output logic             IFIDWriteEnable,
  output logic             IFIDFlush,
  output logic             HoldCapture,
  output logic             IFIDSelHold,
  output logic [CNT_W-1:0] StallCycles
);

  // Boot counter only needs to reach BOOT_CYCLES-1.
  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_t            state;
  state_t            state_nxt;
  ctrl_t             ctrl;
  logic [BOOT_W-1:0] boot_cnt;
  logic              boot_en;
  logic              boot_done;
  logic              stall_inc;
  logic              redir_ok;

  assign boot_en   = (state == S_BOOT);
  // BOOT always lasts at least one cycle, since reset lands there.
  assign boot_done = ((32'(boot_cnt) + 32'd1) >= BOOT_CYCLES);
  // A decode stall masks any redirect in the same cycle.
  assign redir_ok  = Redirect & ~DecodeStall;

  sat_counter #(.W(BOOT_W)) u_boot_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (boot_en),
    .count (boot_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stall_inc),
    .count (StallCycles)
  );

  // Next state, control strobes and stall-count enable.
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    stall_inc = 1'b0;
    case (state)
      S_BOOT: begin
        if (boot_done) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ctrl.imem_req = 1'b1;
        stall_inc     = ~ImemReady;
        if (redir_ok) begin
          // Squash whatever ID would receive; an unfinished request must drain.
          ctrl.pc_we      = 1'b1;
          ctrl.ifid_we    = 1'b1;
          ctrl.ifid_flush = 1'b1;
          if (!ImemReady) state_nxt = S_DRAIN;
        end else if (ImemReady && !DecodeStall) begin
          ctrl.pc_we   = 1'b1;
          ctrl.ifid_we = 1'b1;
        end else if (ImemReady) begin
          // ID is busy: park the returned word and advance PC anyway.
          ctrl.pc_we        = 1'b1;
          ctrl.hold_capture = 1'b1;
          state_nxt         = S_HOLD;
        end
      end
      S_HOLD: begin
        stall_inc = 1'b1;
        if (redir_ok) begin
          ctrl.pc_we      = 1'b1;
          ctrl.ifid_we    = 1'b1;
          ctrl.ifid_flush = 1'b1;
          state_nxt       = S_FETCH;
        end else if (!DecodeStall) begin
          ctrl.ifid_we       = 1'b1;
          ctrl.ifid_sel_hold = 1'b1;
          state_nxt          = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Keep the abandoned request alive until memory answers; data is dropped.
        ctrl.imem_req = 1'b1;
        stall_inc     = ~ImemReady;
        if (redir_ok) begin
          ctrl.pc_we      = 1'b1;
          ctrl.ifid_we    = 1'b1;
          ctrl.ifid_flush = 1'b1;
        end
        if (ImemReady) state_nxt = S_FETCH;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  assign ImemReq         = ctrl.imem_req;
  assign PCWriteEnable   = ctrl.pc_we;
  assign IFIDWriteEnable = ctrl.ifid_we;
  assign IFIDFlush       = ctrl.ifid_flush;
  assign HoldCapture     = ctrl.hold_capture;
  assign IFIDSelHold     = ctrl.ifid_sel_hold;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a cycle table of inputs and expected
// outputs driven through a scoreboard queue, then reset-mid-transaction and
// stall-counter saturation sequences.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ImemReady = 1'b0;
  logic DecodeStall = 1'b0;
  logic Redirect = 1'b0;

  logic        req, pcwe, ifwe, flush, cap, sel;
  logic [15:0] stall;
  logic        req4, pcwe4, ifwe4, flush4, cap4, sel4;
  logic [3:0]  stall4;

  fetch_ctrl #(.BOOT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ImemReady(ImemReady), .DecodeStall(DecodeStall),
    .Redirect(Redirect), .ImemReq(req), .PCWriteEnable(pcwe),
    .IFIDWriteEnable(ifwe), .IFIDFlush(flush), .HoldCapture(cap),
    .IFIDSelHold(sel), .StallCycles(stall)
  );

  fetch_ctrl #(.BOOT_CYCLES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ImemReady(ImemReady), .DecodeStall(DecodeStall),
    .Redirect(Redirect), .ImemReq(req4), .PCWriteEnable(pcwe4),
    .IFIDWriteEnable(ifwe4), .IFIDFlush(flush4), .HoldCapture(cap4),
    .IFIDSelHold(sel4), .StallCycles(stall4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        d;
    logic        x;
    logic [5:0]  ctrl;   // {req, pcwe, ifwe, flush, cap, sel}
    logic [1:0]  st;
    logic [15:0] stall;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(logic r, logic d, logic x, logic [5:0] c,
                             logic [1:0] s, int unsigned n);
    vec_t t;
    t.r = r; t.d = d; t.x = x; t.ctrl = c; t.st = s; t.stall = 16'(n);
    return t;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [5:0] ctrl_now();
    return {req, pcwe, ifwe, flush, cap, sel};
  endfunction

  initial begin
    vec_t e;
    // Boot with memory always ready: 4 idle cycles, then one fetch per cycle.
    for (int i = 0; i < 4; i++) vecs.push_back(v(1, 0, 0, 6'b000000, BOOT, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 0));
    // Two wait states per fetch.
    vecs.push_back(v(0, 0, 0, 6'b100000, FETCH, 0));
    vecs.push_back(v(0, 0, 0, 6'b100000, FETCH, 1));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 2));
    vecs.push_back(v(0, 0, 0, 6'b100000, FETCH, 2));
    vecs.push_back(v(0, 0, 0, 6'b100000, FETCH, 3));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 4));
    // Ready under a decode stall: capture, three HOLD cycles, release.
    vecs.push_back(v(1, 1, 0, 6'b110010, FETCH, 4));
    vecs.push_back(v(0, 1, 0, 6'b000000, HOLD, 4));
    vecs.push_back(v(0, 1, 0, 6'b000000, HOLD, 5));
    vecs.push_back(v(0, 0, 0, 6'b001001, HOLD, 6));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 7));
    // Redirect on first wait cycle of a 3-wait fetch, then drain.
    vecs.push_back(v(0, 0, 1, 6'b111100, FETCH, 7));
    vecs.push_back(v(0, 0, 0, 6'b100000, DRAIN, 8));
    vecs.push_back(v(0, 0, 0, 6'b100000, DRAIN, 9));
    vecs.push_back(v(1, 0, 0, 6'b100000, DRAIN, 10));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 10));
    // Redirect masked by decode stall in FETCH.
    vecs.push_back(v(0, 1, 1, 6'b100000, FETCH, 10));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 11));
    // Masked redirect in HOLD, then a real redirect out of HOLD.
    vecs.push_back(v(1, 1, 0, 6'b110010, FETCH, 11));
    vecs.push_back(v(0, 1, 1, 6'b000000, HOLD, 11));
    vecs.push_back(v(0, 0, 1, 6'b011100, HOLD, 12));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 13));
    // Second redirect while draining.
    vecs.push_back(v(0, 0, 1, 6'b111100, FETCH, 13));
    vecs.push_back(v(0, 0, 1, 6'b111100, DRAIN, 14));
    vecs.push_back(v(1, 0, 0, 6'b100000, DRAIN, 15));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 15));
    // Redirect coinciding with ready: response dropped, stay in FETCH.
    vecs.push_back(v(1, 0, 1, 6'b111100, FETCH, 15));
    vecs.push_back(v(1, 0, 0, 6'b111000, FETCH, 15));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'(ctrl_now()), 32'd0);
    check("rst_state", 32'(dut.state), 32'(BOOT));
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_stall4", 32'(stall4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      ImemReady   = vecs[i].r;
      DecodeStall = vecs[i].d;
      Redirect    = vecs[i].x;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("c%0d_ctrl", i), 32'(ctrl_now()), 32'(e.ctrl));
      check($sformatf("c%0d_state", i), 32'(dut.state), 32'(e.st));
      check($sformatf("c%0d_stall", i), 32'(stall), 32'(e.stall));
      @(posedge clk); #1;
    end

    // Reset while a request is outstanding.
    ImemReady = 1'b0; DecodeStall = 1'b0; Redirect = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("prerst_req", 32'(req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(dut.state), 32'(BOOT));
    check("midrst_ctrl", 32'(ctrl_now()), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);

    // Memory never ready: 16-bit count tracks, 4-bit count pins at 15.
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check($sformatf("sat%0d_state", i), 32'(dut4.state), 32'(FETCH));
      check($sformatf("sat%0d_stall", i), 32'(stall), 32'(i));
      check($sformatf("sat%0d_stall4", i), 32'(stall4), 32'((i > 15) ? 15 : i));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
